// File: rtl/shiftreg_sipo_rx.sv
// Serial-in/parallel-out receiver: assembles MSB-first words into a valid/ready output register.
// Optional even-parity bit per frame enabled by defining SIPO_PARITY_EN.
module shiftreg_sipo_rx #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic         din,
    output logic [N-1:0] dout,
    output logic         valid,
    input  logic         ready,
    output logic         busy,
    output logic         overrun,
    output logic         perr
);

    localparam int CW = $clog2(N + 2);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] PAR_CNT  = CW'(N);
`ifdef SIPO_PARITY_EN
    localparam logic [CW-1:0] LAST_CNT = CW'(N);
`else
    localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);
`endif

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RECV = 2'd1;
    localparam logic [1:0] ST_PAR  = 2'd2;

`ifdef SIPO_PARITY_EN
    // Even parity: a nonzero XOR over data plus parity bit marks an error.
    function automatic logic parity_err(input logic [N-1:0] data, input logic pbit);
        return ^{data, pbit};
    endfunction
`endif

    logic [N-1:0]  shreg_r;
    logic [CW-1:0] cnt_r;
    logic [1:0]    state_s;
    logic [N-1:0]  shift_s;
    logic [N-1:0]  shreg_nxt_s;
    logic [CW-1:0] cnt_nxt_s;
    logic [N-1:0]  word_s;
    logic          complete_s;
    logic          perr_s;

    // State decode from the registered bit count.
    always_comb begin
        state_s = ST_RECV;
        if (cnt_r == CNT_ZERO) begin
            state_s = ST_IDLE;
        end else if (cnt_r == PAR_CNT) begin
            state_s = ST_PAR;
        end else begin
            state_s = ST_RECV;
        end
    end

    // Next shift/count values and word-completion detection.
    always_comb begin
        shift_s     = {shreg_r[N-2:0], din};
        shreg_nxt_s = shreg_r;
        cnt_nxt_s   = cnt_r;
        word_s      = shift_s;
        complete_s  = 1'b0;
        perr_s      = 1'b0;
        if (en) begin
            case (state_s)
                ST_IDLE, ST_RECV: begin
                    shreg_nxt_s = shift_s;
                    if (cnt_r == LAST_CNT) begin
                        cnt_nxt_s  = CNT_ZERO;
                        complete_s = 1'b1;
                    end else begin
                        cnt_nxt_s = cnt_r + CNT_ONE;
                    end
                end
`ifdef SIPO_PARITY_EN
                // Data already assembled; din is the parity bit.
                ST_PAR: begin
                    cnt_nxt_s  = CNT_ZERO;
                    complete_s = 1'b1;
                    word_s     = shreg_r;
                    perr_s     = parity_err(shreg_r, din);
                end
`endif
                default: begin
                    cnt_nxt_s = CNT_ZERO;
                end
            endcase
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

    // Shift register and bit counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg_r <= {N{1'b0}};
            cnt_r   <= CNT_ZERO;
        end else if (clr) begin
            shreg_r <= {N{1'b0}};
            cnt_r   <= CNT_ZERO;
        end else begin
            shreg_r <= shreg_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Output word register with one-word buffering and sticky overrun.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout    <= {N{1'b0}};
            valid   <= 1'b0;
            overrun <= 1'b0;
            perr    <= 1'b0;
        end else if (clr) begin
            valid   <= 1'b0;
            overrun <= 1'b0;
            perr    <= 1'b0;
        end else if (complete_s) begin
            if (!valid || ready) begin
                dout  <= word_s;
                valid <= 1'b1;
                perr  <= perr_s;
            end else begin
                overrun <= 1'b1;
            end
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

    assign busy = (cnt_r != CNT_ZERO);

endmodule

// File: tb/tb_shiftreg_sipo_rx.sv
// Directed bench for shiftreg_sipo_rx (N=8); parity cases build only with SIPO_PARITY_EN.
module tb_shiftreg_sipo_rx;

`ifdef SIPO_PARITY_EN
    localparam int FRAME = 9;
`else
    localparam int FRAME = 8;
`endif

    logic       clk;
    logic       rst;
    logic       clr;
    logic       en;
    logic       din;
    logic [7:0] dout;
    logic       valid;
    logic       ready;
    logic       busy;
    logic       overrun;
    logic       perr;

    int n_assert = 0;
    int n_fail   = 0;

    shiftreg_sipo_rx #(.N(8)) dut (
        .clk(clk), .rst(rst), .clr(clr), .en(en), .din(din),
        .dout(dout), .valid(valid), .ready(ready), .busy(busy),
        .overrun(overrun), .perr(perr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        en  = 1'b1;
        din = b;
        tick();
        en  = 1'b0;
    endtask

    // Bit i of the frame for word w: data MSB first, then even parity when enabled.
    function automatic logic fbit(input logic [7:0] w, input int i);
        logic [8:0] f;
        f = {w, ^w};
        return f[8-i];
    endfunction

    task automatic send_frame(input logic [7:0] w, input logic last_rdy);
        for (int i = 0; i < FRAME; i++) begin
            if (i == FRAME - 1 && last_rdy) ready = 1'b1;
            send_bit(fbit(w, i));
        end
    endtask

    initial begin
        logic [7:0] w;
        rst = 1'b1; clr = 1'b0; en = 1'b0; din = 1'b0; ready = 1'b0;
        #12;
        check("rst_dout", dout, 8'h00);
        check("rst_valid", valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_overrun", overrun, 1'b0);
        check("rst_perr", perr, 1'b0);
        rst = 1'b0;
        tick();

        // Word 0xAA, consecutive strobes, ready high
        ready = 1'b1;
        w = 8'hAA;
        for (int i = 0; i < FRAME; i++) begin
            send_bit(fbit(w, i));
            if (i < FRAME - 1) begin
                check("t2_busy", busy, 1'b1);
                check("t2_valid_early", valid, 1'b0);
            end
        end
        check("t2_dout", dout, 8'hAA);
        check("t2_valid", valid, 1'b1);
        check("t2_busy_end", busy, 1'b0);
        check("t2_perr", perr, 1'b0);
        tick();
        check("t2_valid_drop", valid, 1'b0);
        check("t2_dout_hold", dout, 8'hAA);

        // Overrun: 0xF0 then 0x0F with ready low, then clr
        ready = 1'b0;
        send_frame(8'hF0, 1'b0);
        check("t3_dout1", dout, 8'hF0);
        check("t3_valid1", valid, 1'b1);
        check("t3_ovr1", overrun, 1'b0);
        send_frame(8'h0F, 1'b0);
        check("t3_dout2", dout, 8'hF0);
        check("t3_valid2", valid, 1'b1);
        check("t3_ovr2", overrun, 1'b1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("t3_clr_valid", valid, 1'b0);
        check("t3_clr_ovr", overrun, 1'b0);
        check("t3_clr_dout", dout, 8'hF0);
        check("t3_clr_busy", busy, 1'b0);

        // Interleaved strobes with garbage din on idle cycles
        ready = 1'b1;
        w = 8'h3C;
        for (int i = 0; i < FRAME; i++) begin
            if (i == FRAME - 1) begin
                check("t4_valid_pre", valid, 1'b0);
                check("t4_busy_pre", busy, 1'b1);
            end
            send_bit(fbit(w, i));
            if (i < FRAME - 1) begin
                din = ~fbit(w, i);
                tick();
            end
        end
        check("t4_dout", dout, 8'h3C);
        check("t4_valid", valid, 1'b1);
        tick();
        check("t4_valid_drop", valid, 1'b0);

        // Accept 0x55 on the same edge that completes 0x81
        ready = 1'b0;
        send_frame(8'h55, 1'b0);
        check("t5_dout55", dout, 8'h55);
        send_frame(8'h81, 1'b1);
        ready = 1'b0;
        check("t5_dout", dout, 8'h81);
        check("t5_valid", valid, 1'b1);
        check("t5_ovr", overrun, 1'b0);
        send_frame(8'h00, 1'b0);
        check("t5_ovr_set", overrun, 1'b1);
        check("t5_dout_keep", dout, 8'h81);

        // Async reset mid-word after 3 bits
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        check("t1_busy_pre", busy, 1'b1);
        rst = 1'b1;
        #2;
        check("t1_dout", dout, 8'h00);
        check("t1_valid", valid, 1'b0);
        check("t1_busy", busy, 1'b0);
        check("t1_ovr", overrun, 1'b0);
        rst = 1'b0;
        tick();

`ifdef SIPO_PARITY_EN
        // Parity: 0xA5 with correct then wrong parity bit
        ready = 1'b1;
        w = 8'hA5;
        for (int i = 0; i < 8; i++) send_bit(w[7-i]);
        send_bit(1'b0);
        check("t6_dout", dout, 8'hA5);
        check("t6_perr0", perr, 1'b0);
        check("t6_valid0", valid, 1'b1);
        for (int i = 0; i < 8; i++) send_bit(w[7-i]);
        send_bit(1'b1);
        check("t6_perr1", perr, 1'b1);
        check("t6_valid1", valid, 1'b1);
        check("t6_dout1", dout, 8'hA5);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
